// File: rtl/display_scheduler.sv
// Time/seconds/date/alarm source selector for a 4-digit seven-segment display.
// The selected digits, colon and mode are all registered.
module display_scheduler #(
    parameter int unsigned DATE_HOLD_S = 5,
    parameter bit          LZ_SUPPRESS = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_date,
    input  logic       btn_sec,
    input  logic       alarm_req,
    input  logic [3:0] sec_1s,
    input  logic [3:0] sec_10s,
    input  logic [3:0] min_1s,
    input  logic [3:0] min_10s,
    input  logic [3:0] hr_1s,
    input  logic [3:0] hr_10s,
    input  logic [3:0] day_1s,
    input  logic [3:0] day_10s,
    input  logic [3:0] mon_1s,
    input  logic [3:0] mon_10s,
    output logic [3:0] disp3,
    output logic [3:0] disp2,
    output logic [3:0] disp1,
    output logic [3:0] disp0,
    output logic       colon,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        ST_TIME  = 2'd0,
        ST_SEC   = 2'd1,
        ST_DATE  = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam logic [3:0] BLANK    = 4'hF;
    localparam logic [7:0] HOLD_LIM = 8'(DATE_HOLD_S);

    state_t      state_q, state_d;
    logic        flash_q, flash_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [7:0]  hold_inc;
    logic [15:0] disp_q, disp_d;
    logic        colon_q, colon_d;
    logic [1:0]  mode_q, mode_d;
    logic [15:0] time_digits;
    logic [3:0]  hr_10s_shown;

    // Next-state and flash/hold bookkeeping; alarm_req overrides every other event.
    always_comb begin
        state_d    = state_q;
        flash_d    = flash_q;
        hold_cnt_d = hold_cnt_q;
        hold_inc   = (hold_cnt_q == 8'hFF) ? 8'hFF : hold_cnt_q + 8'd1;

        if (alarm_req) begin
            state_d    = ST_ALARM;
            hold_cnt_d = 8'd0;
            if (state_q != ST_ALARM) begin
                flash_d = 1'b1;
            end else if (tick_1hz) begin
                flash_d = ~flash_q;
            end
        end else begin
            case (state_q)
                ST_TIME: begin
                    if (btn_date) begin
                        state_d    = ST_DATE;
                        flash_d    = 1'b1;
                        hold_cnt_d = 8'd0;
                    end else if (btn_sec) begin
                        state_d = ST_SEC;
                        flash_d = 1'b1;
                    end else if (tick_1hz) begin
                        flash_d = ~flash_q;
                    end
                end
                ST_SEC: begin
                    flash_d = 1'b1;
                    if (btn_date) begin
                        state_d    = ST_DATE;
                        hold_cnt_d = 8'd0;
                    end else if (btn_sec) begin
                        state_d = ST_TIME;
                    end
                end
                ST_DATE: begin
                    flash_d = 1'b1;
                    if (btn_date) begin
                        hold_cnt_d = 8'd0;
                    end else if (tick_1hz) begin
                        if (hold_inc == HOLD_LIM) begin
                            state_d    = ST_TIME;
                            hold_cnt_d = 8'd0;
                        end else begin
                            hold_cnt_d = hold_inc;
                        end
                    end
                end
                default: begin
                    state_d = ST_TIME;
                    flash_d = 1'b1;
                end
            endcase
        end
    end

    // NOTE: outputs are decoded from the next state so a input change shows after one clock.
    always_comb begin
        hr_10s_shown = (LZ_SUPPRESS && hr_10s == 4'd0) ? BLANK : hr_10s;
        time_digits  = {hr_10s_shown, hr_1s, min_10s, min_1s};
        disp_d       = {4{BLANK}};
        colon_d      = 1'b0;
        mode_d       = 2'(state_d);

        case (state_d)
            ST_TIME: begin
                disp_d  = time_digits;
                colon_d = flash_d;
            end
            ST_SEC: begin
                disp_d  = {min_10s, min_1s, sec_10s, sec_1s};
                colon_d = 1'b1;
            end
            ST_DATE: begin
                disp_d  = {day_10s, day_1s, mon_10s, mon_1s};
                colon_d = 1'b1;
            end
            default: begin
                disp_d  = flash_d ? time_digits : {4{BLANK}};
                colon_d = flash_d;
            end
        endcase
    end

    // NOTE: nonblocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_TIME;
            flash_q    <= 1'b1;
            hold_cnt_q <= 8'd0;
            disp_q     <= {4{BLANK}};
            colon_q    <= 1'b0;
            mode_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            flash_q    <= flash_d;
            hold_cnt_q <= hold_cnt_d;
            disp_q     <= disp_d;
            colon_q    <= colon_d;
            mode_q     <= mode_d;
        end
    end

    assign {disp3, disp2, disp1, disp0} = disp_q;
    assign colon = colon_q;
    assign mode  = mode_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: each step pushes its expected display
// onto a scoreboard queue, which is popped and compared one clock later.
module tb_display_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1hz, btn_date, btn_sec, alarm_req;
    logic [3:0] sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s;
    logic [3:0] day_1s, day_10s, mon_1s, mon_10s;
    logic [3:0] disp3, disp2, disp1, disp0;
    logic       colon;
    logic [1:0] mode;

    typedef struct {
        string       tag;
        logic [15:0] disp;
        logic        colon;
        logic [1:0]  mode;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   fails  = 0;

    display_scheduler #(.DATE_HOLD_S(5), .LZ_SUPPRESS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .btn_date(btn_date),
        .btn_sec(btn_sec), .alarm_req(alarm_req),
        .sec_1s(sec_1s), .sec_10s(sec_10s), .min_1s(min_1s), .min_10s(min_10s),
        .hr_1s(hr_1s), .hr_10s(hr_10s), .day_1s(day_1s), .day_10s(day_10s),
        .mon_1s(mon_1s), .mon_10s(mon_10s),
        .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0),
        .colon(colon), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic compare(input exp_t e);
        logic [15:0] d;
        d = {disp3, disp2, disp1, disp0};
        checks++;
        assert (d === e.disp) else begin
            fails++;
            $error("FAIL %s disp: got %h expected %h", e.tag, d, e.disp);
        end
        checks++;
        assert (colon === e.colon) else begin
            fails++;
            $error("FAIL %s colon: got %b expected %b", e.tag, colon, e.colon);
        end
        checks++;
        assert (mode === e.mode) else begin
            fails++;
            $error("FAIL %s mode: got %0d expected %0d", e.tag, mode, e.mode);
        end
    endtask

    // Drive one cycle of events at the falling edge, then check just after the rising edge.
    task automatic step(input string tag, input logic t, input logic bd, input logic bs,
                        input logic al, input logic [15:0] ed, input logic ec,
                        input logic [1:0] em);
        exp_t e;
        @(negedge clk);
        tick_1hz  = t;
        btn_date  = bd;
        btn_sec   = bs;
        alarm_req = al;
        e.tag = tag; e.disp = ed; e.colon = ec; e.mode = em;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            fails++;
            $error("FAIL %s scoreboard: got empty queue expected an entry", tag);
        end else begin
            compare(sb_q.pop_front());
        end
    endtask

    task automatic check_now(input string tag, input logic [15:0] ed, input logic ec,
                             input logic [1:0] em);
        exp_t e;
        e.tag = tag; e.disp = ed; e.colon = ec; e.mode = em;
        compare(e);
    endtask

    localparam logic [15:0] T_DISP = 16'hF745;
    localparam logic [15:0] S_DISP = 16'h4538;
    localparam logic [15:0] D_DISP = 16'h2903;
    localparam logic [15:0] BLANKS = 16'hFFFF;

    initial begin
        rst_n = 1'b0;
        tick_1hz = 1'b0; btn_date = 1'b0; btn_sec = 1'b0; alarm_req = 1'b0;
        hr_10s = 4'd0; hr_1s = 4'd7; min_10s = 4'd4; min_1s = 4'd5;
        sec_10s = 4'd3; sec_1s = 4'd8;
        day_10s = 4'd2; day_1s = 4'd9; mon_10s = 4'd0; mon_1s = 4'd3;

        repeat (2) @(posedge clk);
        #1 check_now("reset", BLANKS, 1'b0, 2'd0);
        @(negedge clk) rst_n = 1'b1;

        // TIME with leading-zero blanking and colon flashing per tick
        step("time_first", 0, 0, 0, 0, T_DISP, 1'b1, 2'd0);
        step("time_tick1", 1, 0, 0, 0, T_DISP, 1'b0, 2'd0);
        step("time_tick2", 1, 0, 0, 0, T_DISP, 1'b1, 2'd0);
        step("time_idle",  0, 0, 0, 0, T_DISP, 1'b1, 2'd0);
        hr_10s = 4'd1;
        step("time_hr10",  0, 0, 0, 0, 16'h1745, 1'b1, 2'd0);
        hr_10s = 4'd0;
        step("time_lz",    0, 0, 0, 0, T_DISP, 1'b1, 2'd0);

        // SEC toggle
        step("sec_enter",  0, 0, 1, 0, S_DISP, 1'b1, 2'd1);
        step("sec_tick",   1, 0, 0, 0, S_DISP, 1'b1, 2'd1);
        step("sec_exit",   0, 0, 1, 0, T_DISP, 1'b1, 2'd0);

        // DATE for five full ticks; the entry tick is not counted, btn_sec ignored
        step("date_enter", 1, 1, 0, 0, D_DISP, 1'b1, 2'd2);
        step("date_t1",    1, 0, 0, 0, D_DISP, 1'b1, 2'd2);
        step("date_t2",    1, 0, 0, 0, D_DISP, 1'b1, 2'd2);
        step("date_bsec",  0, 0, 1, 0, D_DISP, 1'b1, 2'd2);
        step("date_t3",    1, 0, 0, 0, D_DISP, 1'b1, 2'd2);
        step("date_t4",    1, 0, 0, 0, D_DISP, 1'b1, 2'd2);
        step("date_t5",    1, 0, 0, 0, T_DISP, 1'b1, 2'd0);

        // DATE restart after three ticks needs five more
        step("rst_enter",  0, 1, 0, 0, D_DISP, 1'b1, 2'd2);
        for (int i = 0; i < 3; i++) step("rst_pre", 1, 0, 0, 0, D_DISP, 1'b1, 2'd2);
        step("rst_again",  0, 1, 0, 0, D_DISP, 1'b1, 2'd2);
        for (int i = 0; i < 4; i++) step("rst_post", 1, 0, 0, 0, D_DISP, 1'b1, 2'd2);
        step("rst_exit",   1, 0, 0, 0, T_DISP, 1'b1, 2'd0);

        // Both buttons together: DATE wins; then alarm beats btn_date
        step("both_btn",   0, 1, 1, 0, D_DISP, 1'b1, 2'd2);
        step("alm_enter",  0, 1, 0, 1, T_DISP, 1'b1, 2'd3);
        step("alm_tick1",  1, 0, 0, 1, BLANKS, 1'b0, 2'd3);
        step("alm_tick2",  1, 0, 0, 1, T_DISP, 1'b1, 2'd3);
        step("alm_btn",    0, 1, 1, 1, T_DISP, 1'b1, 2'd3);
        step("alm_tick3",  1, 0, 0, 1, BLANKS, 1'b0, 2'd3);
        step("alm_exit",   0, 0, 0, 0, T_DISP, 1'b1, 2'd0);

        // Alarm interrupting DATE returns to TIME
        step("int_date",   0, 1, 0, 0, D_DISP, 1'b1, 2'd2);
        step("int_t1",     1, 0, 0, 0, D_DISP, 1'b1, 2'd2);
        step("int_alarm",  0, 0, 0, 1, T_DISP, 1'b1, 2'd3);
        step("int_exit",   0, 0, 0, 0, T_DISP, 1'b1, 2'd0);

        // Asynchronous reset mid-DATE
        step("ar_date",    0, 1, 0, 0, D_DISP, 1'b1, 2'd2);
        step("ar_t1",      1, 0, 0, 0, D_DISP, 1'b1, 2'd2);
        @(negedge clk);
        tick_1hz = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_now("async_rst", BLANKS, 1'b0, 2'd0);
        @(negedge clk) rst_n = 1'b1;
        step("ar_release", 0, 0, 0, 0, T_DISP, 1'b1, 2'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
